// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Brief    : Unsigned WIDTH x WIDTH radix-2 shift-add multiplier, one bit/cycle.
// Revision : 1.0
// ============================================================================
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic [2*WIDTH-1:0]   PRODUCT,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_busy_next;
    logic                 w_done_next;

    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH:0]     w_acc_next;
    logic                 w_last_step;
    logic                 w_unused;

    // ------------------------------------------------------------------
    // State register (busy/done are registered alongside the state)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)       w_state_next = S_CALC;
            S_CALC:  if (w_last_step) w_state_next = S_DONE;
            S_DONE:                   w_state_next = S_IDLE;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: decoded from the next state so the flops line up
    // with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_next = 1'b0;
        w_done_next = 1'b0;
        case (w_state_next)
            S_CALC:  w_busy_next = 1'b1;
            S_DONE:  w_done_next = 1'b1;
            default: begin
                w_busy_next = 1'b0;
                w_done_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add datapath: add into the upper half with a carry bit, then
    // shift {carry, accumulator} right by one.
    // ------------------------------------------------------------------
    assign w_last_step = (r_cnt == C_LAST_STEP);
    assign w_addend    = r_mplier[0] ? r_mcand : '0;
    assign w_sum       = r_acc[2*WIDTH:WIDTH] + {1'b0, w_addend};
    assign w_acc_next  = {1'b0, w_sum, r_acc[WIDTH-1:1]};

    // Bit 0 of the accumulator falls off the end on every shift.
    assign w_unused    = r_acc[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= X;
                        r_mplier <= Y;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + C_CNT_ONE;
                    if (w_last_step) begin
                        r_product <= w_acc_next[2*WIDTH-1:0];
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign PRODUCT = r_product;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multiplier
// Brief    : Self-checking bench for seq_multiplier (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_seq_multiplier;

    localparam int WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [WIDTH-1:0]     X;
    logic [WIDTH-1:0]     Y;
    logic [2*WIDTH-1:0]   PRODUCT;
    logic                 busy;
    logic                 done;

    typedef struct {
        logic [WIDTH-1:0]   x;
        logic [WIDTH-1:0]   y;
        logic [2*WIDTH-1:0] p;
    } vec_t;

    vec_t                 vecs[9];
    logic [2*WIDTH-1:0]   exp_q[$];
    logic [2*WIDTH-1:0]   sb_exp;
    logic [2*WIDTH-1:0]   last_prod;
    int                   checks = 0;
    int                   failures = 0;
    int                   done_count = 0;
    int                   dc0;
    int                   n;

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .X       (X),
        .Y       (Y),
        .PRODUCT (PRODUCT),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard: every done pulse consumes the oldest expected product.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_product", 32'(PRODUCT), 32'(sb_exp));
            end
        end
    end

    // One isolated operation with full cycle-by-cycle latency checks.
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic [2*WIDTH-1:0] p);
        @(negedge clk);
        X = x; Y = y; start = 1'b1;
        exp_q.push_back(p);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            check("calc_busy", 32'(busy), 32'd1);
            check("calc_no_done", 32'(done), 32'd0);
            check("calc_product_hold", 32'(PRODUCT), 32'(last_prod));
            @(negedge clk);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_not_busy", 32'(busy), 32'd0);
        check("done_product", 32'(PRODUCT), 32'(p));
        last_prod = p;
        @(negedge clk);
        check("idle_done_low", 32'(done), 32'd0);
        check("idle_busy_low", 32'(busy), 32'd0);
        check("idle_product_hold", 32'(PRODUCT), 32'(p));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{8'd21,  8'd10,  16'd210};
        vecs[1] = '{8'd255, 8'd255, 16'd65025};
        vecs[2] = '{8'd0,   8'd99,  16'd0};
        vecs[3] = '{8'd99,  8'd0,   16'd0};
        vecs[4] = '{8'd1,   8'd1,   16'd1};
        vecs[5] = '{8'd255, 8'd1,   16'd255};
        vecs[6] = '{8'd128, 8'd2,   16'd256};
        vecs[7] = '{8'd170, 8'd85,  16'd14450};
        vecs[8] = '{8'd12,  8'd3,   16'd36};

        rst = 1'b1; start = 1'b0; X = '0; Y = '0;
        last_prod = '0;
        @(negedge clk);
        check("reset_product", 32'(PRODUCT), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_start_product", 32'(PRODUCT), 32'd0);
        check("idle_no_start_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 9; v++) begin
            run_op(vecs[v].x, vecs[v].y, vecs[v].p);
        end

        // start held high with operands changing mid-calculation
        @(negedge clk);
        X = 8'd33; Y = 8'd11; start = 1'b1;
        exp_q.push_back(16'd363);
        dc0 = done_count;
        @(negedge clk);
        X = 8'd7; Y = 8'd3;
        for (int i = 0; i < WIDTH; i++) begin
            check("hold_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        check("hold_done", 32'(done), 32'd1);
        check("hold_product", 32'(PRODUCT), 32'd363);
        @(negedge clk);
        check("hold_idle_after_done", 32'(busy), 32'd0);
        check("hold_single_done", 32'(done_count), 32'(dc0 + 1));
        exp_q.push_back(16'd21);
        @(negedge clk);
        check("hold_accept_in_idle", 32'(busy), 32'd1);
        start = 1'b0;
        repeat (WIDTH) @(negedge clk);
        check("hold_second_done", 32'(done), 32'd1);
        check("hold_second_product", 32'(PRODUCT), 32'd21);
        last_prod = 16'd21;
        @(negedge clk);

        // asynchronous reset mid-operation
        @(negedge clk);
        X = 8'd220; Y = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pre_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(PRODUCT), 32'd0);
        dc0 = done_count;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done", 32'(done_count), 32'(dc0));
        check("abort_product_after", 32'(PRODUCT), 32'd0);
        last_prod = '0;
        run_op(8'd5, 8'd6, 16'd30);

        // back-to-back with start held high
        @(negedge clk);
        X = 8'd12; Y = 8'd3; start = 1'b1;
        exp_q.push_back(16'd36);
        exp_q.push_back(16'd6633);
        @(negedge clk);
        X = 8'd99; Y = 8'd67;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_latency", 32'(n), 32'd8);
        check("b2b_first_product", 32'(PRODUCT), 32'd36);
        @(negedge clk);
        n = 1;
        while (done !== 1'b1 && n < 25) begin
            check("b2b_product_stable", 32'(PRODUCT), 32'd36);
            if (busy === 1'b1) start = 1'b0;
            @(negedge clk);
            n++;
        end
        check("b2b_spacing", 32'(n), 32'd10);
        check("b2b_second_product", 32'(PRODUCT), 32'd6633);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_idle", 32'(busy), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
